// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU register-file widths and typedefs for decode, writeback and benches.
package cpu_pkg;
  localparam int DATA_W = 19;
  localparam int NREGS = 16;
  localparam int ADDR_W = 4;
  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: decode/writeback bundle of the scoreboarded register file.
interface regfile_sb_if #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W
);
  logic we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic rpend1;
  logic rpend2;
  logic rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic any_pend;
  logic sb_err;
  logic err_clr;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  modport master (
    output we, waddr, wdata, raddr1, raddr2, rsv_en, rsv_addr, err_clr, dbg_addr,
    input rdata1, rdata2, rpend1, rpend2, any_pend, sb_err, dbg_data
  );
  modport slave (
    input we, waddr, wdata, raddr1, raddr2, rsv_en, rsv_addr, err_clr, dbg_addr,
    output rdata1, rdata2, rpend1, rpend2, any_pend, sb_err, dbg_data
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending bits, reserve/clear priority, sticky error and any_pend.
module regfile_scoreboard #(
  parameter int NREGS = cpu_pkg::NREGS,
  parameter int ADDR_W = $clog2(NREGS),
  parameter bit ZERO_REG = 1'b1
) (
  input logic clk,
  input logic rst,
  input logic we,
  input logic [ADDR_W-1:0] waddr,
  input logic rsv_en,
  input logic [ADDR_W-1:0] rsv_addr,
  input logic err_clr,
  output logic [NREGS-1:0] pend,
  output logic any_pend,
  output logic sb_err
);
  import cpu_pkg::*;
  logic w_ok;
  logic r_ok;
  logic err_set;
  logic [NREGS-1:0] pend_n;
  always_comb begin
    w_ok = we && !(ZERO_REG && waddr == '0);
    r_ok = rsv_en && !(ZERO_REG && rsv_addr == '0);
    pend_n = pend;
    if (w_ok) pend_n[waddr] = 1'b0;
    // reserve applied after the clear so a new producer wins over the completing one
    if (r_ok) pend_n[rsv_addr] = 1'b1;
    err_set = r_ok && pend[rsv_addr] && !(w_ok && waddr == rsv_addr);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
      any_pend <= 1'b0;
      sb_err <= 1'b0;
    end else begin
      pend <= pend_n;
      any_pend <= |pend_n;
      sb_err <= err_set || (sb_err && !err_clr);
    end
  end
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: 2-read/1-write register file with bypass, pending scoreboard and debug read port.
module regfile_sb #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int NREGS = cpu_pkg::NREGS,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS = 1'b1
) (
  input logic clk,
  input logic rst,
  regfile_sb_if.slave bus
);
  localparam int ADDR_W = $clog2(NREGS);
  import cpu_pkg::*;
  logic [DATA_W-1:0] mem [NREGS];
  logic [NREGS-1:0] pend;
  logic w_ok;
  logic byp1;
  logic byp2;
  logic z1;
  logic z2;
  assign w_ok = bus.we && !(ZERO_REG && bus.waddr == '0);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem <= '{default: '0};
    else if (w_ok) mem[bus.waddr] <= bus.wdata;
  end
  // storage is already zero in reset; only the forwarded write data needs masking
  assign byp1 = BYPASS && !rst && bus.we && bus.waddr == bus.raddr1;
  assign byp2 = BYPASS && !rst && bus.we && bus.waddr == bus.raddr2;
  assign z1 = ZERO_REG && bus.raddr1 == '0;
  assign z2 = ZERO_REG && bus.raddr2 == '0;
  assign bus.rdata1 = z1 ? '0 : byp1 ? bus.wdata : mem[bus.raddr1];
  assign bus.rdata2 = z2 ? '0 : byp2 ? bus.wdata : mem[bus.raddr2];
  assign bus.rpend1 = !z1 && !byp1 && pend[bus.raddr1];
  assign bus.rpend2 = !z2 && !byp2 && pend[bus.raddr2];
  assign bus.dbg_data = (ZERO_REG && bus.dbg_addr == '0) ? '0 : mem[bus.dbg_addr];
  regfile_scoreboard #(.NREGS(NREGS), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_sb (
    .clk(clk),
    .rst(rst),
    .we(bus.we),
    .waddr(bus.waddr),
    .rsv_en(bus.rsv_en),
    .rsv_addr(bus.rsv_addr),
    .err_clr(bus.err_clr),
    .pend(pend),
    .any_pend(bus.any_pend),
    .sb_err(bus.sb_err)
  );
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: randomized scoreboard bench for the default and a 32x32 no-zero/no-bypass regfile_sb.
module tb_regfile_sb;
  import cpu_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  regfile_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) a();
  regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) b();
  regfile_sb dut_a (.clk(clk), .rst(rst), .bus(a));
  regfile_sb #(.DATA_W(32), .NREGS(32), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(b));
  typedef struct {
    string tag;
    bit is_b;
    logic [31:0] r1, r2, dbg;
    logic p1, p2, ap, err;
  } exp_t;
  exp_t q[$];
  exp_t m;
  int n_cmp = 0;
  int n_bad = 0;
  word_t mem_a[16];
  bit pend_a[16];
  bit err_a;
  logic [31:0] mem_b[32];
  bit pend_b[32];
  bit err_b;

  task automatic chk(string tag, string f, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %h expected %h at %0t", tag, f, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    #2;
    while (q.size() > 0) begin
      m = q.pop_front();
      if (m.is_b) begin
        chk(m.tag, "rdata1", b.rdata1, m.r1);
        chk(m.tag, "rdata2", b.rdata2, m.r2);
        chk(m.tag, "rpend1", 32'(b.rpend1), 32'(m.p1));
        chk(m.tag, "rpend2", 32'(b.rpend2), 32'(m.p2));
        chk(m.tag, "any_pend", 32'(b.any_pend), 32'(m.ap));
        chk(m.tag, "sb_err", 32'(b.sb_err), 32'(m.err));
        chk(m.tag, "dbg_data", b.dbg_data, m.dbg);
      end else begin
        chk(m.tag, "rdata1", 32'(a.rdata1), m.r1);
        chk(m.tag, "rdata2", 32'(a.rdata2), m.r2);
        chk(m.tag, "rpend1", 32'(a.rpend1), 32'(m.p1));
        chk(m.tag, "rpend2", 32'(a.rpend2), 32'(m.p2));
        chk(m.tag, "any_pend", 32'(a.any_pend), 32'(m.ap));
        chk(m.tag, "sb_err", 32'(a.sb_err), 32'(m.err));
        chk(m.tag, "dbg_data", 32'(a.dbg_data), m.dbg);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic void clear_models();
    for (int i = 0; i < 16; i++) begin mem_a[i] = '0; pend_a[i] = 0; end
    for (int i = 0; i < 32; i++) begin mem_b[i] = '0; pend_b[i] = 0; end
    err_a = 0;
    err_b = 0;
  endfunction

  function automatic bit any_a();
    for (int i = 0; i < 16; i++) if (pend_a[i]) return 1;
    return 0;
  endfunction

  function automatic bit any_b();
    for (int i = 0; i < 32; i++) if (pend_b[i]) return 1;
    return 0;
  endfunction

  // zero register and forwarding rules of the default configuration
  function automatic logic [31:0] rd_a(logic [3:0] ra, bit we, logic [3:0] wa, word_t wd);
    if (rst || ra == 0) return 0;
    if (we && wa == ra) return 32'(wd);
    return 32'(mem_a[ra]);
  endfunction

  function automatic bit pd_a(logic [3:0] ra, bit we, logic [3:0] wa);
    if (rst || ra == 0) return 0;
    if (we && wa == ra) return 0;
    return pend_a[ra];
  endfunction

  task automatic idle_all();
    a.we = 0; a.rsv_en = 0; a.err_clr = 0;
    b.we = 0; b.rsv_en = 0; b.err_clr = 0;
  endtask

  task automatic cyc_a(string tag, bit we, logic [3:0] wa, word_t wd, logic [3:0] r1, logic [3:0] r2,
                       bit rs, logic [3:0] ra, bit clr, logic [3:0] da);
    exp_t e;
    bit wr, rv, en;
    @(negedge clk);
    idle_all();
    a.we = we; a.waddr = wa; a.wdata = wd; a.raddr1 = r1; a.raddr2 = r2;
    a.rsv_en = rs; a.rsv_addr = ra; a.err_clr = clr; a.dbg_addr = da;
    #1;
    e.tag = tag; e.is_b = 0;
    e.r1 = rd_a(r1, we, wa, wd);
    e.r2 = rd_a(r2, we, wa, wd);
    e.p1 = pd_a(r1, we, wa);
    e.p2 = pd_a(r2, we, wa);
    e.ap = any_a();
    e.err = err_a;
    e.dbg = (da == 0) ? 0 : 32'(mem_a[da]);
    q.push_back(e);
    if (!rst) begin
      wr = we && wa != 0;
      rv = rs && ra != 0;
      en = rv && pend_a[ra] && !(wr && wa == ra);
      if (wr) begin mem_a[wa] = wd; pend_a[wa] = 0; end
      if (rv) pend_a[ra] = 1;
      err_a = en || (err_a && !clr);
    end
  endtask

  task automatic cyc_b(string tag, bit we, logic [4:0] wa, logic [31:0] wd, logic [4:0] r1, logic [4:0] r2,
                       bit rs, logic [4:0] ra, bit clr, logic [4:0] da);
    exp_t e;
    bit en;
    @(negedge clk);
    idle_all();
    b.we = we; b.waddr = wa; b.wdata = wd; b.raddr1 = r1; b.raddr2 = r2;
    b.rsv_en = rs; b.rsv_addr = ra; b.err_clr = clr; b.dbg_addr = da;
    #1;
    e.tag = tag; e.is_b = 1;
    e.r1 = mem_b[r1];
    e.r2 = mem_b[r2];
    e.p1 = pend_b[r1];
    e.p2 = pend_b[r2];
    e.ap = any_b();
    e.err = err_b;
    e.dbg = mem_b[da];
    q.push_back(e);
    if (!rst) begin
      en = rs && pend_b[ra] && !(we && wa == ra);
      if (we) begin mem_b[wa] = wd; pend_b[wa] = 0; end
      if (rs) pend_b[ra] = 1;
      err_b = en || (err_b && !clr);
    end
  endtask

  initial begin
    logic [3:0] wa, ra;
    logic [4:0] wb, rb;
    a.we = 0; a.waddr = 0; a.wdata = 0; a.raddr1 = 0; a.raddr2 = 0;
    a.rsv_en = 0; a.rsv_addr = 0; a.err_clr = 0; a.dbg_addr = 0;
    b.we = 0; b.waddr = 0; b.wdata = 0; b.raddr1 = 0; b.raddr2 = 0;
    b.rsv_en = 0; b.rsv_addr = 0; b.err_clr = 0; b.dbg_addr = 0;
    clear_models();
    cyc_a("rst_a", 1, 3, 19'h1111, 3, 5, 1, 5, 0, 3);
    cyc_b("rst_b", 1, 3, 32'h1111, 3, 5, 1, 5, 0, 3);
    @(negedge clk); idle_all(); rst = 0;
    // reset mid-operation
    cyc_a("w5r7", 1, 5, 19'h1234, 5, 7, 1, 7, 0, 5);
    cyc_a("chk5", 0, 0, 0, 5, 7, 0, 0, 0, 5);
    @(posedge clk); #2; rst = 1; clear_models();
    cyc_a("inrst", 1, 5, 19'h55, 5, 7, 1, 5, 0, 5);
    @(negedge clk); idle_all(); rst = 0;
    cyc_a("post5", 0, 0, 0, 5, 7, 0, 0, 0, 5);
    // bypass and zero register
    cyc_a("byp", 1, 3, 19'h7FFFF, 3, 0, 0, 0, 0, 3);
    cyc_a("zw", 1, 0, 19'd5, 0, 3, 0, 0, 0, 0);
    cyc_a("zr", 0, 0, 0, 0, 3, 1, 0, 0, 0);
    // scoreboard lifecycle
    cyc_a("rsv4", 0, 0, 0, 4, 0, 1, 4, 0, 4);
    cyc_a("pend4", 0, 0, 0, 4, 4, 0, 0, 0, 4);
    cyc_a("wr4", 1, 4, 19'd42, 4, 1, 0, 0, 0, 4);
    cyc_a("done4", 0, 0, 0, 4, 0, 0, 0, 0, 4);
    // simultaneous reserve and write
    cyc_a("rw6", 1, 6, 19'h3A5A5, 6, 2, 1, 6, 0, 6);
    cyc_a("chk6", 0, 0, 0, 6, 2, 0, 0, 0, 6);
    cyc_a("clr6", 1, 6, 19'h1, 6, 0, 0, 0, 0, 6);
    // double reserve and sticky error
    cyc_a("r9a", 0, 0, 0, 9, 0, 1, 9, 0, 9);
    cyc_a("r9b", 0, 0, 0, 9, 0, 1, 9, 0, 9);
    cyc_a("err1", 0, 0, 0, 9, 0, 0, 0, 0, 9);
    cyc_a("hold", 0, 0, 0, 9, 0, 0, 0, 0, 9);
    cyc_a("eclr", 0, 0, 0, 9, 0, 0, 0, 1, 9);
    cyc_a("err0", 0, 0, 0, 9, 0, 1, 9, 1, 9);
    cyc_a("setwin", 0, 0, 0, 9, 0, 0, 0, 1, 9);
    cyc_a("w9", 1, 9, 19'h99, 9, 0, 0, 0, 0, 9);
    for (int i = 0; i < 400; i++) begin
      wa = 4'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom);
      cyc_a("rand_a", 1'($urandom), wa, 19'($urandom),
            ($urandom_range(0, 2) == 0) ? wa : 4'($urandom), 4'($urandom),
            $urandom_range(0, 2) == 0, ra, $urandom_range(0, 7) == 0, 4'($urandom));
    end
    // parameter sweep instance
    cyc_b("wr0", 1, 0, 32'hDEADBEEF, 0, 1, 0, 0, 0, 0);
    cyc_b("rd0", 0, 0, 0, 0, 1, 0, 0, 0, 0);
    cyc_b("rsv0", 0, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc_b("pend0", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 200; i++) begin
      wb = 5'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? wb : 5'($urandom);
      cyc_b("rand_b", 1'($urandom), wb, $urandom,
            ($urandom_range(0, 2) == 0) ? wb : 5'($urandom), 5'($urandom),
            $urandom_range(0, 3) == 0, rb, $urandom_range(0, 7) == 0, 5'($urandom));
    end
    for (int i = 0; i < 32; i++) cyc_b("dbg_b", 0, 0, 0, 5'(i), 5'(31 - i), 0, 0, 0, 5'(i));
    @(negedge clk); idle_all();
    repeat (2) @(negedge clk);
    #5;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the CPU's 19-bit, 16-entry, 2-read/1-write register file.
- Adds:
  - asynchronous reset of all storage;
  - write-to-read bypass (same-cycle forwarding);
  - a per-register pending scoreboard, so multi-cycle producers (loads, multiplier) can reserve a destination and the decode stage can stall on it;
  - a selectable debug read port in place of fixed debug taps.
- Sits between decode (read and reserve) and writeback (write and clear).

Parameters:
- DATA_W, 19, register width in bits.
- NREGS, 16, number of architectural registers; must be a power of 2 and at least 2.
- ADDR_W, $clog2(NREGS), register address width; derived, not overridden.
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes and reservations; when 0 it is an ordinary register.
- BYPASS, 1, when 1 a same-cycle write is forwarded to the read ports.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- we  in  1  write enable (writeback).
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- raddr1  in  ADDR_W  read port 1 address.
- raddr2  in  ADDR_W  read port 2 address.
- rdata1  out  DATA_W  read port 1 data.
- rdata2  out  DATA_W  read port 2 data.
- rpend1  out  1  register at raddr1 is pending.
- rpend2  out  1  register at raddr2 is pending.
- rsv_en  in  1  reserve (mark pending) request.
- rsv_addr  in  ADDR_W  register to reserve.
- any_pend  out  1  at least one register is pending.
- sb_err  out  1  sticky error: reserve issued on an already-pending register.
- err_clr  in  1  clears sb_err.
- dbg_addr  in  ADDR_W  debug read address.
- dbg_data  out  DATA_W  debug read data (no bypass).

Behaviour:
- Reset (rst=1, asynchronous):
  - all registers, all pending bits and sb_err clear to 0 immediately;
  - while reset is held, all outputs read 0 and writes and reservations are ignored.
- Write:
  - when we=1 at the clk edge, the addressed register is updated with wdata and its pending bit is cleared;
  - with ZERO_REG=1 and waddr=0 the write is dropped.
  - Write latency is 1 cycle.
  - Writing a register that is not pending is legal (normal ALU writeback) and sets no error.
- Read (combinational):
  - rdataN = 0 if ZERO_REG and raddrN=0;
  - else wdata if BYPASS, we=1 and waddr=raddrN;
  - else the stored value.
- Pending flags (combinational):
  - rpendN = pending bit of raddrN, qualified as follows.
  - A same-cycle write to raddrN with BYPASS=1 forces rpendN=0, because the data is being forwarded.
  - With ZERO_REG=1, raddrN=0 always reports 0.
- Reserve:
  - rsv_en=1 at the clk edge sets pend[rsv_addr].
  - With ZERO_REG=1, a reserve of address 0 is ignored.
  - If pend[rsv_addr] is already 1 and no write to the same address occurs that cycle, sb_err is set, and pending stays 1.
- Simultaneous reserve and write to the same register:
  - the write's data is stored;
  - the reserve wins, so pending ends at 1 (a new producer is issued behind the completing one);
  - no error is raised.
- Simultaneous reserve and write to different registers: both take effect independently.
- any_pend is registered-equivalent: the OR of all pending bits after the edge, with no combinational path from inputs.
- sb_err:
  - it is sticky and cleared by err_clr at a clk edge;
  - if err_clr and a new error occur in the same cycle, the set wins and sb_err stays 1.
- dbg_data is the stored array value at dbg_addr, forced to 0 for address 0 when ZERO_REG=1; it has no bypass.
- No simulation-only $display inside synthesizable logic; write tracing belongs in the bench.

Decomposition:
- A shared package `cpu_pkg` holds:
  - DATA_W=19, NREGS=16, ADDR_W=4;
  - the `reg_addr_t` and `word_t` typedefs, for use by decode, writeback and the bench.
- One sub-module, `regfile_scoreboard`, owns the pending bit vector, the reserve/clear priority, sb_err and any_pend.
- The top module holds the storage array, the bypass muxes and the debug mux.

Test Plan:
1. Reset mid-operation:
   - write R5=0x1234 and reserve R7, then assert rst asynchronously between edges;
   - require rdata, any_pend and sb_err to go to 0 immediately, and R5 to read 0 after release.
2. Bypass and zero register:
   - in the same cycle drive we=1, waddr=3, wdata=0x7FFFF, raddr1=3 and raddr2=0;
   - require rdata1=0x7FFFF and rdata2=0 in that cycle.
   - Then drive we=1, waddr=0, wdata=5; require R0 to still read 0.
3. Scoreboard lifecycle:
   - reserve R4; the next cycle require rpend1=1 (raddr1=4) and any_pend=1;
   - write R4=42; in the write cycle require rpend1=0 and rdata1=42; afterwards pend=0 and any_pend=0.
4. Simultaneous reserve and write on R6:
   - require R6 to take wdata, pend[6]=1 afterwards, and sb_err=0.
5. Double reserve:
   - reserve R9 twice on consecutive cycles;
   - require sb_err=1 and to stay 1 until err_clr, then 0.
   - Also pulse err_clr in the same cycle as a new double reserve; require sb_err=1.
6. Parameter sweep:
   - instantiate DATA_W=32, NREGS=32, ZERO_REG=0, BYPASS=0;
   - write R0=0xDEADBEEF, then require it to read back 0xDEADBEEF on the next cycle and not during the write cycle.
   - Require dbg_data to match for all 32 addresses.
